// File: rtl/bsred_pkg.sv
// Shared types and elaboration helpers for the pseudo-Mersenne bit-serial reducer.
// Contents: FSM state enum, pm_p() returning p = 2^len - c, and pm_ok() checking
// that c lies in the range where two folds plus one conditional subtract fully reduce.
package bsred_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FOLD1,
    FOLD2,
    FINAL,
    OUT
  } state_e;

  // Modulus p = 2^len - c.
  function automatic int unsigned pm_p(input int unsigned len, input int unsigned c);
    return (32'd1 << len) - c;
  endfunction

  // Legal when 1 <= c and c*c + 2*c < 2^len. This bound keeps the second fold below 2p.
  function automatic bit pm_ok(input int unsigned len, input int unsigned c);
    logic [63:0] cc;
    cc = 64'(c) * 64'(c) + 64'(c) + 64'(c);
    return (c >= 32'd1) && (cc < (64'd1 << len));
  endfunction

endpackage

// File: rtl/bsred_pm_fold.sv
// Combinational fold: sum = lo + hi * C.
// Ports: lo_i (LW bits), hi_i (HW bits), sum_c_o (OW bits, combinational).
// The caller sizes OW so that the sum cannot overflow.
module bsred_pm_fold #(
  parameter int unsigned LW = 5,
  parameter int unsigned HW = 5,
  parameter int unsigned C  = 3,
  parameter int unsigned OW = 8
) (
  input  logic [LW-1:0] lo_i,
  input  logic [HW-1:0] hi_i,
  output logic [OW-1:0] sum_c_o
);

  assign sum_c_o = OW'(lo_i) + OW'(hi_i) * OW'(C);

endmodule

// File: rtl/bsred_pm.sv
// Bit-serial reducer: 2*LEN-bit operand in (LSB first), canonical residue mod
// p = 2^LEN - C out (LSB first). Two word-parallel folds plus one compare-subtract.
// Ports: clk, reset (async, active low), is/isync (serial operand + bit-0 pulse),
//        qs/osync (serial residue + bit-0 pulse), busy, and ovr when BSRED_PM_OVR_EN
//        is defined (sticky flag for ignored isync pulses).
module bsred_pm
  import bsred_pkg::*;
#(
  parameter int unsigned LEN = 5,
  parameter int unsigned C   = 3,
  parameter int unsigned CW  = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic is,
  input  logic isync,
  output logic qs,
  output logic osync,
  output logic busy
`ifdef BSRED_PM_OVR_EN
  ,
  output logic ovr
`endif
);

  localparam int unsigned XW   = 2 * LEN;
  localparam int unsigned AW   = LEN + CW + 1;
  localparam int unsigned HW   = (LEN > CW + 1) ? LEN : CW + 1;
  localparam int unsigned CNTW = $clog2(2 * LEN);
  localparam int unsigned KW   = $clog2(LEN);
  localparam int unsigned P    = pm_p(LEN, C);

  // Elaboration-time legality checks.
  if (!pm_ok(LEN, C)) begin : g_bad_c
    $error("bsred_pm: C=%0d illegal for LEN=%0d", C, LEN);
  end
  if (C >= (32'd1 << CW)) begin : g_bad_cw
    $error("bsred_pm: C=%0d does not fit in CW=%0d bits", C, CW);
  end

  state_e            state_q, state_d;
  logic [XW-1:0]     in_sr_q, in_sr_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [LEN-1:0]    out_sr_q, out_sr_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [KW-1:0]     outk_q, outk_d;
  logic              ld_act_q, ld_act_d;
  logic              qs_q, qs_d;
  logic              osync_q, osync_d;
  logic              busy_q, busy_d;

  logic [XW-1:0]     shift_in_c;
  logic [LEN-1:0]    fold_lo;
  logic [HW-1:0]     fold_hi;
  logic [AW-1:0]     fold_sum;
  logic [LEN-1:0]    r_c;

  assign shift_in_c = {is, in_sr_q[XW-1:1]};

  // Final conditional subtract; acc_q < 2p here.
  assign r_c = (acc_q >= AW'(P)) ? LEN'(acc_q - AW'(P)) : LEN'(acc_q);

  // One fold unit shared by FOLD1 and FOLD2 via the operand mux below.
  bsred_pm_fold #(
    .LW (LEN),
    .HW (HW),
    .C  (C),
    .OW (AW)
  ) u_fold (
    .lo_i    (fold_lo),
    .hi_i    (fold_hi),
    .sum_c_o (fold_sum)
  );

  // Next-state, datapath and registered-output logic.
  always_comb begin : comb_next
    state_d  = state_q;
    in_sr_d  = in_sr_q;
    acc_d    = acc_q;
    out_sr_d = out_sr_q;
    cnt_d    = cnt_q;
    outk_d   = outk_q;
    ld_act_d = ld_act_q;
    fold_lo  = in_sr_q[LEN-1:0];
    fold_hi  = HW'(in_sr_q[XW-1:LEN]);
    qs_d     = 1'b0;
    osync_d  = 1'b0;
    busy_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (isync) begin
          in_sr_d = shift_in_c;
          cnt_d   = CNTW'(1);
          state_d = LOAD;
        end
      end
      LOAD: begin
        in_sr_d = shift_in_c;
        if (cnt_q == CNTW'(2 * LEN - 1)) begin
          state_d = FOLD1;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      FOLD1: begin
        acc_d   = fold_sum;
        state_d = FOLD2;
      end
      FOLD2: begin
        fold_lo = acc_q[LEN-1:0];
        fold_hi = HW'(acc_q[LEN+CW:LEN]);
        acc_d   = fold_sum;
        state_d = FINAL;
      end
      FINAL: begin
        out_sr_d = r_c >> 1;
        outk_d   = '0;
        ld_act_d = 1'b0;
        state_d  = OUT;
      end
      OUT: begin
        // The next operand may start loading while this residue shifts out.
        if (ld_act_q) begin
          in_sr_d = shift_in_c;
          cnt_d   = cnt_q + CNTW'(1);
        end else if (isync) begin
          in_sr_d  = shift_in_c;
          cnt_d    = CNTW'(1);
          ld_act_d = 1'b1;
        end
        out_sr_d = out_sr_q >> 1;
        outk_d   = outk_q + KW'(1);
        if (outk_q == KW'(LEN - 1)) begin
          state_d  = (ld_act_q || isync) ? LOAD : IDLE;
          ld_act_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    if (state_d == OUT) begin
      if (state_q == FINAL) begin
        qs_d    = r_c[0];
        osync_d = 1'b1;
      end else begin
        qs_d = out_sr_q[0];
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      in_sr_q  <= '0;
      acc_q    <= '0;
      out_sr_q <= '0;
      cnt_q    <= '0;
      outk_q   <= '0;
      ld_act_q <= 1'b0;
      qs_q     <= 1'b0;
      osync_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_sr_q  <= in_sr_d;
      acc_q    <= acc_d;
      out_sr_q <= out_sr_d;
      cnt_q    <= cnt_d;
      outk_q   <= outk_d;
      ld_act_q <= ld_act_d;
      qs_q     <= qs_d;
      osync_q  <= osync_d;
      busy_q   <= busy_d;
    end
  end

  assign qs    = qs_q;
  assign osync = osync_q;
  assign busy  = busy_q;

`ifdef BSRED_PM_OVR_EN
  // Sticky overrun: isync while an operand is still being loaded or folded.
  logic ovr_q;
  logic ovr_set_c;

  assign ovr_set_c = isync && ((state_q inside {LOAD, FOLD1, FOLD2, FINAL}) ||
                               ((state_q == OUT) && ld_act_q));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovr_q <= 1'b0;
    end else begin
      ovr_q <= ovr_q | ovr_set_c;
    end
  end

  assign ovr = ovr_q;
`endif

endmodule

// File: tb/tb_bsred_pm.sv
// Directed and random checks of bsred_pm at LEN=5/C=3 (p=29) and LEN=16/C=15 (p=65521).
module tb_bsred_pm;

  logic clk;
  logic rst_n;
  logic is5, isync5, qs5, osync5, busy5;
  logic is16, isync16, qs16, osync16, busy16;
`ifdef BSRED_PM_OVR_EN
  logic ovr5, ovr16;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int t_is5 = 0;

  localparam int LAT = 13;  // 2*LEN + 3 for LEN=5
  localparam int N16 = 1000;

  bsred_pm #(.LEN(5), .C(3), .CW(2)) u5 (
    .clk   (clk),
    .reset (rst_n),
    .is    (is5),
    .isync (isync5),
    .qs    (qs5),
    .osync (osync5),
    .busy  (busy5)
`ifdef BSRED_PM_OVR_EN
    ,
    .ovr   (ovr5)
`endif
  );

  bsred_pm #(.LEN(16), .C(15), .CW(4)) u16 (
    .clk   (clk),
    .reset (rst_n),
    .is    (is16),
    .isync (isync16),
    .qs    (qs16),
    .osync (osync16),
    .busy  (busy16)
`ifdef BSRED_PM_OVR_EN
    ,
    .ovr   (ovr16)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog");
  end

  // Residue collectors: one record per osync, LSB first.
  logic [4:0]  acc5;
  int          k5 = 0;
  int          os5_n = 0;
  logic [4:0]  r5_q[$];
  int          tos5_q[$];

  always @(negedge clk) begin
    if (osync5) begin
      acc5 = '0;
      acc5[0] = qs5;
      k5 = 1;
      tos5_q.push_back(cyc);
      os5_n++;
    end else if (k5 > 0) begin
      acc5[k5] = qs5;
      k5++;
    end
    if (k5 == 5) begin
      r5_q.push_back(acc5);
      k5 = 0;
    end
  end

  logic [15:0] acc16;
  int          k16 = 0;
  logic [15:0] r16_q[$];

  always @(negedge clk) begin
    if (osync16) begin
      acc16 = '0;
      acc16[0] = qs16;
      k16 = 1;
    end else if (k16 > 0) begin
      acc16[k16] = qs16;
      k16++;
    end
    if (k16 == 16) begin
      r16_q.push_back(acc16);
      k16 = 0;
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Serialise a 10-bit operand; an extra isync is raised on bit index 'extra'.
  task automatic send5(input logic [9:0] x, input int extra);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      isync5 = (i == 0) || (i == extra);
      is5    = x[i];
      if (i == 0) t_is5 = cyc;
    end
    @(negedge clk);
    isync5 = 1'b0;
    is5    = 1'b0;
  endtask

  task automatic wait_res5(output logic [4:0] r, output int tos);
    int g;
    r   = '0;
    tos = -1000;
    g   = 0;
    while (r5_q.size() == 0 && g < 80) begin
      @(negedge clk);
      g++;
    end
    if (r5_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL res5_timeout: no residue within %0d cycles, expected one", g);
    end else begin
      r   = r5_q.pop_front();
      tos = tos5_q.pop_front();
    end
  endtask

  typedef struct {
    logic [9:0] x;
    logic [4:0] r;
  } vec_t;

  vec_t tv[12];

  initial begin
    logic [4:0]  r;
    int          tos, tos1, t1, t2, n_os, g;
    logic [31:0] x16;
    logic [15:0] e16[$];
    logic [31:0] spec16[5];

    rst_n = 1'b0; is5 = 1'b0; isync5 = 1'b0; is16 = 1'b0; isync16 = 1'b0;

    tv[0]  = '{10'd0,    5'd0};
    tv[1]  = '{10'd28,   5'd28};
    tv[2]  = '{10'd29,   5'd0};
    tv[3]  = '{10'd58,   5'd0};
    tv[4]  = '{10'd1023, 5'd8};
    tv[5]  = '{10'd1000, 5'd14};
    tv[6]  = '{10'd500,  5'd7};
    tv[7]  = '{10'd30,   5'd1};
    tv[8]  = '{10'd841,  5'd0};
    tv[9]  = '{10'd1015, 5'd0};
    tv[10] = '{10'd59,   5'd1};
    tv[11] = '{10'd57,   5'd28};

    repeat (3) @(negedge clk);
    check("rst_qs", qs5, 0);
    check("rst_osync", osync5, 0);
    check("rst_busy", busy5, 0);
    rst_n = 1'b1;
    @(negedge clk);
`ifdef BSRED_PM_OVR_EN
    check("ovr_init", ovr5, 0);
`endif

    // Single operands through the table.
    for (int i = 0; i < 12; i++) begin
      send5(tv[i].x, -1);
      wait_res5(r, tos);
      check($sformatf("res_%0d", tv[i].x), r, tv[i].r);
      check($sformatf("lat_%0d", tv[i].x), tos - t_is5, LAT);
      @(negedge clk);
      @(negedge clk);
      check($sformatf("busy_after_%0d", tv[i].x), busy5, 0);
    end

    // Back-to-back: second isync on the last residue bit of the first operand.
    send5(10'd1023, -1);
    t1 = t_is5;
    g = 0;
    while (cyc != t1 + 16 && g < 40) begin
      @(negedge clk);
      g++;
    end
    send5(10'd30, -1);
    t2 = t_is5;
    check("b2b_busy", busy5, 1);
    wait_res5(r, tos1);
    check("b2b_res1", r, 8);
    check("b2b_lat1", tos1 - t1, LAT);
    check("b2b_no_gap", t2 - tos1, 4);
    wait_res5(r, tos);
    check("b2b_res2", r, 1);
    check("b2b_lat2", tos - t2, LAT);
    check("b2b_os_spacing", tos - tos1, 17);
    repeat (2) @(negedge clk);

    // Overrun in LOAD cycle 4 must not disturb the operand.
    send5(10'd1000, 4);
    wait_res5(r, tos);
    check("ovr_res", r, 14);
    check("ovr_lat", tos - t_is5, LAT);
    repeat (2) @(negedge clk);
`ifdef BSRED_PM_OVR_EN
    check("ovr_set", ovr5, 1);
`endif
    send5(10'd28, -1);
    wait_res5(r, tos);
    check("post_ovr_res", r, 28);
    repeat (2) @(negedge clk);
`ifdef BSRED_PM_OVR_EN
    check("ovr_sticky", ovr5, 1);
`endif

    // Reset during LOAD aborts the operand.
    n_os = os5_n;
    @(negedge clk); isync5 = 1'b1; is5 = 1'b1;
    repeat (3) begin @(negedge clk); isync5 = 1'b0; is5 = 1'b1; end
    @(negedge clk); rst_n = 1'b0; is5 = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_busy", busy5, 0);
    check("midrst_qs", qs5, 0);
`ifdef BSRED_PM_OVR_EN
    check("midrst_ovr", ovr5, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    send5(10'd500, -1);
    wait_res5(r, tos);
    check("midrst_res", r, 7);
    check("midrst_lat", tos - t_is5, LAT);
    check("midrst_osync_count", os5_n - n_os, 1);
    repeat (4) @(negedge clk);

    // LEN=16, C=15: pipelined operands, one isync every 35 cycles.
    spec16[0] = 32'd0;
    spec16[1] = 32'd65521;
    spec16[2] = 32'd65520;
    spec16[3] = 32'hFFFF_FFFF;
    spec16[4] = 32'd4293001441;  // 65521^2
    for (int n = 0; n < N16; n++) begin
      x16 = (n < 5) ? spec16[n] : $urandom();
      e16.push_back(16'(64'(x16) % 64'd65521));
      for (int b = 0; b < 32; b++) begin
        @(negedge clk);
        isync16 = (b == 0);
        is16    = x16[b];
      end
      repeat (3) begin
        @(negedge clk);
        isync16 = 1'b0;
        is16    = 1'b0;
      end
    end
    g = 0;
    while (r16_q.size() < N16 && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("r16_count", r16_q.size(), N16);
    for (int n = 0; n < N16 && r16_q.size() > 0; n++) begin
      check($sformatf("r16_%0d", n), r16_q.pop_front(), e16[n]);
    end
    repeat (2) @(negedge clk);
    check("busy16_end", busy16, 0);
`ifdef BSRED_PM_OVR_EN
    check("ovr16_end", ovr16, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
